cb_desegment: RTL and testbench

- Receive-side counterpart of the code-block segmentation data path.
- Consumes the segmented byte stream (filler bytes, data bytes, optional 3-byte CRC24B per code block) with its per-byte flags.
- Strips filler and CRC, re-emits payload bytes with block delimiters, and checks each code block's CRC24B.
- Sits between the encoder-side FIFO loopback / decoder output and the transport-block reassembly logic.

---
 rtl/cb_desegment.sv | 190 +++++++++++++++++++
 tb/tb_cb_desegment.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cb_desegment.sv
// Receive-side code-block desegmenter: strips filler and CRC bytes, re-emits the
// payload with block delimiters and checks each block's CRC24B.
module cb_desegment #(
  parameter int unsigned K_LARGE  = 768,
  parameter int unsigned K_SMALL  = 132,
  parameter logic [23:0] CRC_POLY = 24'h800063
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       in_start_i,
  input  logic       in_block_size_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  input  logic       in_filling_i,
  input  logic       in_crc_i,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic       out_sob_o,
  output logic       out_eob_o,
  output logic       crc_done_o,
  output logic       crc_present_o,
  output logic       crc_ok_o,
  output logic       err_proto_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CRCB = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [15:0] KL = 16'(K_LARGE);
  localparam logic [15:0] KS = 16'(K_SMALL);

  typedef struct packed {
    logic       valid;
    logic       sob;
    logic       eob;
    logic [7:0] data;
  } beat_t;

  typedef struct packed {
    logic done;
    logic present;
    logic ok;
  } crc_rsp_t;

  function automatic logic [23:0] crc_byte(input logic [23:0] c, input logic [7:0] d);
    logic [23:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[23] ^ d[i]) r = {r[22:0], 1'b0} ^ CRC_POLY;
      else              r = {r[22:0], 1'b0};
    end
    return r;
  endfunction

  function automatic beat_t mk_beat(input logic v, input logic s, input logic e,
                                    input logic [7:0] d);
    beat_t b;
    b = '0;
    if (v) b = '{valid: 1'b1, sob: s, eob: e, data: d};
    return b;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] crc_q, crc_d;
  logic [23:0] rx_q, rx_d;
  logic [2:0]  ncrc_q, ncrc_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        first_q, first_d;
  beat_t       beat_q, beat_d;
  crc_rsp_t    rsp_q, rsp_d;
  logic        err_q, err_d;

  logic in_blk, acc;

  assign in_blk = (state_q == S_FILL) || (state_q == S_DATA) || (state_q == S_CRCB);
  assign acc    = in_blk && in_valid_i && (cnt_q != 16'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    rx_d       = rx_q;
    ncrc_d     = ncrc_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    first_d    = first_q;
    beat_d     = '0;
    rsp_d      = '0;
    err_d      = 1'b0;

    if (in_start_i) begin
      // Abort of an open block flushes the held byte as the block's last one.
      err_d = in_valid_i | in_blk;
      if (in_blk) beat_d = mk_beat(hold_vld_q, first_q, 1'b1, hold_q);
      state_d    = S_FILL;
      cnt_d      = in_block_size_i ? KL : KS;
      crc_d      = '0;
      rx_d       = '0;
      ncrc_d     = '0;
      hold_vld_d = 1'b0;
      first_d    = 1'b1;
    end else if (acc) begin
      cnt_d      = cnt_q - 16'd1;
      beat_d     = mk_beat(hold_vld_q, first_q, in_crc_i, hold_q);
      hold_vld_d = 1'b0;
      if (hold_vld_q) first_d = 1'b0;
      if (in_crc_i) begin
        rx_d    = {rx_q[15:0], in_data_i};
        ncrc_d  = (ncrc_q == 3'd7) ? ncrc_q : ncrc_q + 3'd1;
        err_d   = (state_q == S_FILL);
        state_d = S_CRCB;
      end else if (state_q == S_CRCB) begin
        err_d = 1'b1;
      end else begin
        crc_d = crc_byte(crc_q, in_data_i);
        if (in_filling_i) begin
          err_d = (state_q == S_DATA);
        end else begin
          hold_d     = in_data_i;
          hold_vld_d = 1'b1;
          state_d    = S_DATA;
        end
      end
    end else begin
      // Bytes outside an open block (or past its length) are dropped.
      err_d = in_valid_i;
      if (in_blk && cnt_q == 16'd0) begin
        state_d    = S_DONE;
        beat_d     = mk_beat(hold_vld_q, first_q, 1'b1, hold_q);
        hold_vld_d = 1'b0;
        if (hold_vld_q) first_d = 1'b0;
        rsp_d.done = 1'b1;
        case (ncrc_q)
          3'd0: begin rsp_d.present = 1'b0; rsp_d.ok = 1'b1; end
          3'd3: begin rsp_d.present = 1'b1; rsp_d.ok = (rx_q == crc_q); end
          default: begin
            rsp_d.present = 1'b1;
            rsp_d.ok      = 1'b0;
            err_d         = 1'b1;
          end
        endcase
      end else if (state_q == S_DONE) begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      crc_q      <= '0;
      rx_q       <= '0;
      ncrc_q     <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      first_q    <= 1'b0;
      beat_q     <= '0;
      rsp_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      rx_q       <= rx_d;
      ncrc_q     <= ncrc_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      first_q    <= first_d;
      beat_q     <= beat_d;
      rsp_q      <= rsp_d;
      err_q      <= err_d;
    end
  end

  assign out_valid_o   = beat_q.valid;
  assign out_data_o    = beat_q.data;
  assign out_sob_o     = beat_q.sob;
  assign out_eob_o     = beat_q.eob;
  assign crc_done_o    = rsp_q.done;
  assign crc_present_o = rsp_q.present;
  assign crc_ok_o      = rsp_q.ok;
  assign err_proto_o   = err_q;

endmodule

// File: tb/tb_cb_desegment.sv
// Directed bench for cb_desegment: a negedge monitor logs output beats and
// CRC/error pulses; the main sequence drives blocks and checks the logs.
module tb_cb_desegment;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_start = 1'b0, in_block_size = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_filling = 1'b0, in_crc = 1'b0;
  logic       out_valid, out_sob, out_eob, crc_done, crc_present, crc_ok, err_proto;
  logic [7:0] out_data;

  cb_desegment dut (
    .clk_i(clk), .reset_i(reset), .in_start_i(in_start), .in_block_size_i(in_block_size),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_filling_i(in_filling), .in_crc_i(in_crc),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_sob_o(out_sob), .out_eob_o(out_eob),
    .crc_done_o(crc_done), .crc_present_o(crc_present), .crc_ok_o(crc_ok),
    .err_proto_o(err_proto)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; logic sob; logic eob; int cyc; } beat_t;
  beat_t bq[$];
  int    n_done = 0, done_cyc = 0, n_err = 0, err_cyc = 0;
  logic  dp = 1'b0, dok = 1'b0;

  always @(negedge clk) begin
    if (out_valid) bq.push_back('{out_data, out_sob, out_eob, cyc});
    if (crc_done) begin n_done++; done_cyc = cyc; dp = crc_present; dok = crc_ok; end
    if (err_proto) begin n_err++; err_cyc = cyc; end
  end

  int tests = 0, fails = 0;
  int bb, db, eb, mism, t;
  logic [7:0] msg[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic st, input logic bs, input logic v, input logic [7:0] d,
                     input logic f, input logic c);
    in_start = st; in_block_size = bs; in_valid = v; in_data = d; in_filling = f; in_crc = c;
    @(posedge clk); #1;
    in_start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_filling = 1'b0; in_crc = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic mark();
    bb = bq.size(); db = n_done; eb = n_err;
  endtask

  // Polynomial long division of msg * x^24 by the generator.
  function automatic logic [23:0] crc_ref();
    logic [24:0] r;
    r = '0;
    foreach (msg[k]) for (int b = 7; b >= 0; b--) begin
      r = {r[23:0], msg[k][b]};
      if (r[24]) r = r ^ 25'h1800063;
    end
    for (int b = 0; b < 24; b++) begin
      r = {r[23:0], 1'b0};
      if (r[24]) r = r ^ 25'h1800063;
    end
    return r[23:0];
  endfunction

  task automatic large_blk(input logic [7:0] b100, output int tc);
    drv(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 765; i++) drv(1'b0, 1'b0, 1'b1, (i == 100) ? b100 : 8'h00, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    tc = cyc;
    drv(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    idle(3);
  endtask

  initial begin
    logic [23:0] c;
    idle(3);
    chk("reset outputs", 32'({out_valid, out_data, out_sob, out_eob, crc_done,
                              crc_present, crc_ok, err_proto}), 32'd0);
    reset = 1'b1;
    idle(2);

    // K_SMALL, 10 filler + 122 data, no CRC
    mark();
    drv(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drv(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 1; i <= 122; i++) drv(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    idle(3);
    chk("t1 nbytes", bq.size() - bb, 122);
    mism = 0;
    for (int i = 0; i < 122; i++)
      if (bq[bb+i].d !== 8'(i + 1) || bq[bb+i].sob !== (i == 0) || bq[bb+i].eob !== (i == 121))
        mism++;
    chk("t1 data/flags", mism, 0);
    chk("t1 ndone", n_done - db, 1);
    chk("t1 present", 32'(dp), 0);
    chk("t1 ok", 32'(dok), 1);
    chk("t1 eob in done cycle", bq[bb+121].cyc, done_cyc);
    chk("t1 err", n_err - eb, 0);

    // K_LARGE, 765 zeros + CRC 000000
    mark();
    large_blk(8'h00, t);
    chk("t2 nbytes", bq.size() - bb, 765);
    chk("t2 sob first", 32'(bq[bb].sob), 1);
    chk("t2 eob last", 32'(bq[bb+764].eob), 1);
    chk("t2 eob after crc byte", bq[bb+764].cyc, t);
    chk("t2 present", 32'(dp), 1);
    chk("t2 ok", 32'(dok), 1);
    chk("t2 err", n_err - eb, 0);

    // Same, byte 100 corrupted
    mark();
    large_blk(8'h80, t);
    chk("t3 byte100", 32'(bq[bb+99].d), 32'h80);
    chk("t3 ndone", n_done - db, 1);
    chk("t3 present", 32'(dp), 1);
    chk("t3 ok", 32'(dok), 0);
    chk("t3 err", n_err - eb, 0);

    // K_SMALL, 130 data + only 2 CRC bytes
    mark();
    drv(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 130; i++) drv(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b1, 8'h34, 1'b0, 1'b1);
    idle(3);
    chk("t4 nbytes", bq.size() - bb, 130);
    chk("t4 present", 32'(dp), 1);
    chk("t4 ok", 32'(dok), 0);
    chk("t4 err count", n_err - eb, 1);
    chk("t4 err in done cycle", err_cyc, done_cyc);

    // K_SMALL, 129 data + correct CRC
    mark();
    msg.delete();
    for (int i = 0; i < 129; i++) msg.push_back(8'((i * 37 + 5) & 255));
    c = crc_ref();
    drv(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    foreach (msg[k]) drv(1'b0, 1'b0, 1'b1, msg[k], 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b1, c[23:16], 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b1, c[15:8], 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b1, c[7:0], 1'b0, 1'b1);
    idle(3);
    chk("t5 ndone", n_done - db, 1);
    chk("t5 present", 32'(dp), 1);
    chk("t5 ok", 32'(dok), 1);
    chk("t5 err", n_err - eb, 0);

    // Abort a K_LARGE block after 50 bytes, then K_SMALL with gaps
    mark();
    drv(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) drv(1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    drv(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    t = cyc;
    for (int i = 0; i < 5; i++) begin
      idle($urandom_range(0, 2));
      drv(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    end
    for (int i = 0; i < 127; i++) begin
      idle($urandom_range(0, 2));
      drv(1'b0, 1'b0, 1'b1, 8'((i * 5 + 3) & 255), 1'b0, 1'b0);
    end
    idle(4);
    chk("t6 err count", n_err - eb, 1);
    chk("t6 err cycle", err_cyc, t);
    chk("t6 aborted byte", 32'(bq[bb+49].d), 32'h41);
    chk("t6 aborted eob", 32'(bq[bb+49].eob), 1);
    chk("t6 aborted eob cycle", bq[bb+49].cyc, t);
    chk("t6 nbytes", bq.size() - bb, 177);
    mism = 0;
    for (int i = 0; i < 127; i++)
      if (bq[bb+50+i].d !== 8'((i * 5 + 3) & 255) || bq[bb+50+i].sob !== (i == 0) ||
          bq[bb+50+i].eob !== (i == 126))
        mism++;
    chk("t6 second block", mism, 0);
    chk("t6 ndone", n_done - db, 1);
    chk("t6 ok", 32'({dp, dok}), 32'b01);

    // start+valid together, then reset mid-DATA
    mark();
    drv(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drv(1'b0, 1'b0, 1'b1, 8'(i + 1), 1'b0, 1'b0);
    reset = 1'b0;
    drv(1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
    reset = 1'b1;
    chk("t7 outputs after reset", 32'({out_valid, out_data, out_sob, out_eob, crc_done,
                                       crc_present, crc_ok, err_proto}), 32'd0);
    chk("t7 start+valid err", n_err - eb, 1);
    chk("t7 bytes before reset", bq.size() - bb, 19);
    mark();
    for (int i = 0; i < 5; i++) drv(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    idle(4);
    chk("t7 err after reset", n_err - eb, 5);
    chk("t7 no output after reset", bq.size() - bb, 0);
    chk("t7 no done after reset", n_done - db, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
